// File: rtl/req_ack_arbiter.sv
// Round-robin arbiter that shares one upstream level-req/one-cycle-ack source among
// num_req requesters. One fetch is in flight at a time and each word goes to exactly one requester.
module req_ack_arbiter #(
    parameter int num_req    = 4,
    parameter int data_width = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [num_req-1:0]         req_in,
    output logic [num_req-1:0]         ack_out,
    output logic [data_width-1:0]      dout,
    output logic                       up_req,
    input  logic                       up_ack,
    input  logic [data_width-1:0]      up_din,
    output logic [$clog2(num_req)-1:0] grant,
    output logic                       busy,
    output logic [31:0]                count
);
    localparam int GW = $clog2(num_req);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ACK} state_t;

    state_t                state, state_n;
    logic [GW-1:0]         ptr, ptr_n, grant_n, win;
    logic                  found;
    logic [num_req-1:0]    ack_n;
    logic [data_width-1:0] dout_n;
    logic                  up_req_n;
    logic [31:0]           count_n;

    // First requesting index at or after ptr, wrapping modulo num_req.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        for (int k = 0; k < num_req; k++) begin
            idx = int'(ptr) + k;
            if (idx >= num_req) idx = idx - num_req;
            if (!found && req_in[idx[GW-1:0]]) begin
                found = 1'b1;
                win   = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        grant_n  = grant;
        ack_n    = '0;
        dout_n   = dout;
        up_req_n = up_req;
        count_n  = count;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_n  = win;
                    ptr_n    = (win == GW'(num_req - 1)) ? '0 : win + GW'(1);
                    up_req_n = 1'b1;
                    state_n  = FETCH;
                end
            end
            FETCH: begin
                if (up_ack) begin
                    dout_n   = up_din;
                    up_req_n = 1'b0;
                    if (req_in[grant]) begin
                        ack_n[grant] = 1'b1;
                        count_n      = count + 32'd1;
                        state_n      = ACK;
                    end else begin
                        state_n = HOLD;
                    end
                end
            end
            // The fetched word stays reserved for the withdrawn requester.
            HOLD: begin
                if (req_in[grant]) begin
                    ack_n[grant] = 1'b1;
                    count_n      = count + 32'd1;
                    state_n      = ACK;
                end
            end
            // req_in is deliberately ignored here: the acked requester is still dropping its req.
            ACK: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            grant   <= '0;
            ack_out <= '0;
            dout    <= '0;
            up_req  <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            grant   <= grant_n;
            ack_out <= ack_n;
            dout    <= dout_n;
            up_req  <= up_req_n;
            count   <= count_n;
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_req_ack_arbiter.sv
// Bench for req_ack_arbiter: vector table, hand-written corner sequences, randomized run
// against a transaction-level reference model, and a saturated throughput run.
module tb_req_ack_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_in;
    logic [NR-1:0] ack_out;
    logic [DW-1:0] dout;
    logic          up_req;
    logic          up_ack;
    logic [DW-1:0] up_din;
    logic [1:0]    grant;
    logic          busy;
    logic [31:0]   count;

    always #5 clk = ~clk;

    req_ack_arbiter #(.num_req(NR), .data_width(DW)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .ack_out(ack_out), .dout(dout),
        .up_req(up_req), .up_ack(up_ack), .up_din(up_din), .grant(grant),
        .busy(busy), .count(count)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] prod = 0;
    bit up_stall = 0;
    int cons [NR];

    // Reference model: who owns the in-flight transaction and whether its word has arrived.
    int            owner = -1;
    bit            fetched = 0;
    bit            recover = 0;
    int            ptr_m = 0;
    logic [NR-1:0] m_ack = '0;
    logic          m_up_req = 0, m_busy = 0;
    logic [1:0]    m_grant = 0;
    logic [31:0]   m_dout = 0, m_count = 0;

    typedef struct {
        logic        r;
        logic [3:0]  req;
        logic [3:0]  ack;
        logic        upr;
        logic        bsy;
        logic [1:0]  gnt;
        logic [31:0] dout;
        logic [31:0] cnt;
    } vec_t;
    vec_t tbl[$];
    logic [31:0] t_dout = 0, t_cnt = 0, t_word = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge();
        int i;
        m_ack = '0;
        if (rst) begin
            owner = -1; fetched = 0; recover = 0; ptr_m = 0;
            m_up_req = 0; m_dout = 0; m_grant = 0; m_count = 0;
        end else if (recover) begin
            recover = 0;
        end else if (owner < 0) begin
            for (int k = 0; k < NR; k++) begin
                i = (ptr_m + k) % NR;
                if (owner < 0 && req_in[i[1:0]]) owner = i;
            end
            if (owner >= 0) begin
                ptr_m = (owner + 1) % NR;
                m_grant = owner[1:0];
                m_up_req = 1;
            end
        end else begin
            if (!fetched && up_ack) begin
                m_dout = up_din; m_up_req = 0; fetched = 1;
            end
            if (fetched && req_in[owner[1:0]]) begin
                m_ack[owner[1:0]] = 1'b1;
                m_count = m_count + 1;
                owner = -1; fetched = 0; recover = 1;
            end
        end
        m_busy = (owner >= 0) || recover;
    endtask

    // One clock: model sees the same pre-edge inputs as the DUT; upstream acks one edge after req.
    task automatic step();
        logic pr, pa;
        pr = up_req;
        pa = up_ack;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (pr === 1'b1 && pa === 1'b0 && (!up_stall || $urandom_range(1, 0) == 1)) begin
            up_ack = 1'b1;
            up_din = prod;
            prod   = prod + 1;
        end else begin
            up_ack = 1'b0;
        end
        for (int k = 0; k < NR; k++) if (ack_out[k] === 1'b1) cons[k]++;
    endtask

    task automatic chk_model();
        chk("mdl_ack",    64'(ack_out), 64'(m_ack));
        chk("mdl_up_req", 64'(up_req),  64'(m_up_req));
        chk("mdl_grant",  64'(grant),   64'(m_grant));
        chk("mdl_busy",   64'(busy),    64'(m_busy));
        chk("mdl_count",  64'(count),   64'(m_count));
        chk("mdl_dout",   64'(dout),    64'(m_dout));
    endtask

    task automatic wait_ack(input int idx, input logic [31:0] exp_d, input int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (ack_out === '0 && n < limit);
        chk("wait_ack_onehot", 64'(ack_out), 64'(4'b0001 << idx));
        chk("wait_ack_dout",   64'(dout),    64'(exp_d));
    endtask

    task automatic add_txn(input logic [3:0] rq, input int idx);
        logic [3:0] a;
        a = 4'b0001 << idx;
        tbl.push_back('{1'b0, rq, 4'b0000, 1'b1, 1'b1, 2'(idx), t_dout, t_cnt});
        tbl.push_back('{1'b0, rq, 4'b0000, 1'b1, 1'b1, 2'(idx), t_dout, t_cnt});
        t_dout = t_word;
        t_word = t_word + 1;
        t_cnt  = t_cnt + 1;
        tbl.push_back('{1'b0, rq, a,       1'b0, 1'b1, 2'(idx), t_dout, t_cnt});
        tbl.push_back('{1'b0, rq, 4'b0000, 1'b0, 1'b0, 2'(idx), t_dout, t_cnt});
    endtask

    task automatic add_rst(input logic [3:0] rq);
        tbl.push_back('{1'b1, rq, 4'b0000, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0});
        t_dout = 0;
        t_cnt  = 0;
    endtask

    initial begin
        logic [31:0] w, pr;
        int edges, sum;
        logic [NR-1:0] drop_pend;

        rst = 1'b1; req_in = '0; up_ack = 1'b0; up_din = '0;
        for (int k = 0; k < NR; k++) cons[k] = 0;

        // Single requester, fresh round-robin after reset, then pointer wrap from ptr=3.
        add_rst(4'b0000);
        for (int k = 0; k < 4; k++) add_txn(4'b0001, 0);
        add_rst(4'b1111);
        for (int k = 0; k < 8; k++) add_txn(4'b1111, k % 4);
        add_txn(4'b0100, 2);
        add_txn(4'b0011, 0);
        add_txn(4'b0011, 1);

        foreach (tbl[k]) begin
            rst = tbl[k].r;
            req_in = tbl[k].req;
            step();
            chk("tbl_ack",    64'(ack_out), 64'(tbl[k].ack));
            chk("tbl_up_req", 64'(up_req),  64'(tbl[k].upr));
            chk("tbl_busy",   64'(busy),    64'(tbl[k].bsy));
            chk("tbl_grant",  64'(grant),   64'(tbl[k].gnt));
            chk("tbl_dout",   64'(dout),    64'(tbl[k].dout));
            chk("tbl_count",  64'(count),   64'(tbl[k].cnt));
            chk_model();
        end

        // Withdraw during FETCH: word is held for requester 1, requester 2 waits.
        rst = 1'b0;
        req_in = 4'b0010;
        step();
        chk("wd_grant", 64'(grant), 64'd1);
        req_in = 4'b0100;
        step();
        chk("wd_fetch_up_req", 64'(up_req), 64'd1);
        w = up_din;
        step();
        chk("wd_hold_ack",  64'(ack_out), 64'd0);
        chk("wd_hold_busy", 64'(busy),    64'd1);
        chk("wd_hold_dout", 64'(dout),    64'(w));
        for (int k = 0; k < 10; k++) begin
            step();
            chk("wd_hold_idle", 64'({ack_out, up_req, busy, grant}), 64'({4'b0000, 1'b0, 1'b1, 2'd1}));
        end
        req_in = 4'b0110;
        step();
        chk("wd_ack1",  64'(ack_out), 64'(4'b0010));
        chk("wd_dout1", 64'(dout),    64'(w));
        req_in = 4'b0100;
        step();
        step();
        chk("wd_grant2", 64'(grant), 64'd2);
        wait_ack(2, w + 1, 10);
        chk_model();

        // Reset while up_req is high: the word is abandoned and arbitration restarts at 0.
        req_in = 4'b0001;
        step();
        step();
        chk("rf_up_req_before", 64'(up_req), 64'd1);
        rst = 1'b1;
        pr = prod;
        step();
        chk("rf_reset_outs", 64'({up_req, ack_out, busy, grant}), 64'd0);
        chk("rf_reset_count", 64'(count), 64'd0);
        chk("rf_reset_dout",  64'(dout),  64'd0);
        rst = 1'b0;
        req_in = 4'b1001;
        step();
        chk("rf_restart_grant", 64'(grant), 64'd0);
        wait_ack(0, pr + 1, 10);
        chk("rf_count", 64'(count), 64'd1);
        chk_model();

        // Randomized requesters and upstream stalls against the reference model.
        up_stall = 1;
        drop_pend = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (drop_pend[k]) begin
                    req_in[k] = 1'b0;
                    drop_pend[k] = 1'b0;
                end else if (ack_out[k]) begin
                    drop_pend[k] = 1'b1;
                end else if (!req_in[k]) begin
                    req_in[k] = ($urandom_range(3, 0) == 0);
                end else if ($urandom_range(15, 0) == 0) begin
                    req_in[k] = 1'b0;
                end
            end
            rst = ($urandom_range(499, 0) == 0);
            step();
            chk_model();
        end

        // Saturated throughput: one word every 4 cycles, ack k lands on edge 4k-1.
        up_stall = 0;
        rst = 1'b1;
        req_in = 4'b1111;
        step();
        rst = 1'b0;
        for (int k = 0; k < NR; k++) cons[k] = 0;
        edges = 0;
        while (count !== 32'd5000 && edges < 25000) begin
            step();
            edges++;
        end
        chk("tp_edges", 64'(edges), 64'd19999);
        chk("tp_count", 64'(count), 64'd5000);
        sum = 0;
        for (int k = 0; k < NR; k++) begin
            sum += cons[k];
            chk("tp_per_req", 64'(cons[k]), 64'd1250);
        end
        chk("tp_sum", 64'(count), 64'(sum));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
